// File: rtl/tcp_msg_poller_dispatch_pkg.sv
// Shared definitions for the TCP message-poller dispatch block: flow id width,
// request-memory record layout, destination tile widths and the dispatch FSM
// state encoding. The MSG_SRC_* widths can be overridden by the surrounding
// build; the defaults below apply when nothing else defines them.
`ifndef MSG_SRC_X_WIDTH
`define MSG_SRC_X_WIDTH 8
`endif
`ifndef MSG_SRC_Y_WIDTH
`define MSG_SRC_Y_WIDTH 8
`endif
`ifndef MSG_SRC_FBITS_WIDTH
`define MSG_SRC_FBITS_WIDTH 4
`endif

package tcp_msg_poller_dispatch_pkg;

    localparam int MAX_FLOW_CNT = 256;
    localparam int FLOWID_W     = $clog2(MAX_FLOW_CNT);
    localparam int MSG_LEN_W    = 16;
    localparam int DST_X_W      = `MSG_SRC_X_WIDTH;
    localparam int DST_Y_W      = `MSG_SRC_Y_WIDTH;
    localparam int DST_FBITS_W  = `MSG_SRC_FBITS_WIDTH;

    // Stored per-flow poll request: how many bytes the app wants and where
    // to send the notification once they are available.
    typedef struct packed {
        logic [MSG_LEN_W-1:0]   tx_length;
        logic [DST_X_W-1:0]     dst_x;
        logic [DST_Y_W-1:0]     dst_y;
        logic [DST_FBITS_W-1:0] dst_fbits;
    } msg_req_mem_struct;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_META = 3'd1,
        ST_CHECK   = 3'd2,
        ST_NOTIFY  = 3'd3,
        ST_REQUEUE = 3'd4
    } dispatch_state_e;

endpackage

// File: rtl/tcp_msg_poller_dispatch_datap.sv
// Datapath for the poller dispatch: holds the in-flight flow id, the captured
// request metadata and the available-byte count, and produces the
// "enough bytes committed" decision from registered operands.
module tcp_msg_poller_dispatch_datap
    import tcp_msg_poller_dispatch_pkg::*;
#(
    parameter int POLLER_PTR_W = MSG_LEN_W
) (
    input  logic                    clk,
    input  logic                    capture_flowid,
    input  logic [FLOWID_W-1:0]     flowid_in,
    input  logic                    capture_meta,
    input  msg_req_mem_struct       meta_in,
    input  logic [POLLER_PTR_W-1:0] head_in,
    input  logic [POLLER_PTR_W-1:0] commit_in,
    output logic [FLOWID_W-1:0]     flowid,
    output logic [POLLER_PTR_W-1:0] avail,
    output logic [DST_X_W-1:0]      dst_x,
    output logic [DST_Y_W-1:0]      dst_y,
    output logic [DST_FBITS_W-1:0]  dst_fbits,
    output logic                    enough
);

    logic [FLOWID_W-1:0]     flowid_p0;
    logic [POLLER_PTR_W-1:0] tx_len_p1;
    logic [POLLER_PTR_W-1:0] avail_p1;
    logic [DST_X_W-1:0]      dst_x_p1;
    logic [DST_Y_W-1:0]      dst_y_p1;
    logic [DST_FBITS_W-1:0]  dst_fbits_p1;

    // Stage 0: flow id latched on the pop cycle
    always_ff @(posedge clk) begin
        if (capture_flowid) begin
            flowid_p0 <= flowid_in;
        end
    end

    // Stage 1: memory responses captured; commit - head wraps modulo 2^W,
    // so a commit pointer that has passed zero still yields the right count
    always_ff @(posedge clk) begin
        if (capture_meta) begin
            tx_len_p1    <= POLLER_PTR_W'(meta_in.tx_length);
            avail_p1     <= commit_in - head_in;
            dst_x_p1     <= meta_in.dst_x;
            dst_y_p1     <= meta_in.dst_y;
            dst_fbits_p1 <= meta_in.dst_fbits;
        end
    end

    // A zero-length request is satisfied unconditionally
    assign enough    = (tx_len_p1 == '0) || (avail_p1 >= tx_len_p1);
    assign flowid    = flowid_p0;
    assign avail     = avail_p1;
    assign dst_x     = dst_x_p1;
    assign dst_y     = dst_y_p1;
    assign dst_fbits = dst_fbits_p1;

endmodule

// File: rtl/tcp_msg_poller_dispatch.sv
// Consumer end of the TCP message-poller request path. Pops a pending flow id,
// reads its stored request and RX pointers, then either notifies the
// requesting tile (and clears the flow's active bit) or re-enqueues the flow
// for a later poll. One request is in flight at a time.
// Optional build macro TCP_MSG_POLLER_DISPATCH_STATS_EN adds saturating
// notify/requeue handshake counters.
module tcp_msg_poller_dispatch
    import tcp_msg_poller_dispatch_pkg::*;
#(
    parameter int POLLER_PTR_W = MSG_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    msg_req_q_empty,
    input  logic [FLOWID_W-1:0]     msg_req_q_rd_data,
    output logic                    msg_req_q_rd_req,
    output logic                    msg_req_q_wr_req_val,
    output logic [FLOWID_W-1:0]     msg_req_q_wr_req_data,
    input  logic                    msg_req_q_wr_req_rdy,
    output logic [FLOWID_W-1:0]     msg_req_mem_rd_req_addr,
    input  msg_req_mem_struct       msg_req_mem_rd_resp_data,
    output logic [FLOWID_W-1:0]     ptr_mem_rd_req_addr,
    input  logic [POLLER_PTR_W-1:0] ptr_mem_rd_resp_head,
    input  logic [POLLER_PTR_W-1:0] ptr_mem_rd_resp_commit,
    output logic                    active_bitvec_clear_val,
    output logic [FLOWID_W-1:0]     active_bitvec_clear_flowid,
    output logic                    poller_dst_msg_val,
    input  logic                    poller_dst_msg_rdy,
    output logic [FLOWID_W-1:0]     poller_dst_msg_flowid,
    output logic [POLLER_PTR_W-1:0] poller_dst_msg_len,
    output logic [DST_X_W-1:0]      poller_dst_msg_dst_x,
    output logic [DST_Y_W-1:0]      poller_dst_msg_dst_y,
    output logic [DST_FBITS_W-1:0]  poller_dst_msg_dst_fbits
`ifdef TCP_MSG_POLLER_DISPATCH_STATS_EN
    ,
    output logic [31:0]             stat_notify_cnt,
    output logic [31:0]             stat_requeue_cnt
`endif
);

    dispatch_state_e state, state_next;

    logic                    capture_flowid;
    logic                    capture_meta;
    logic [FLOWID_W-1:0]     dp_flowid;
    logic [POLLER_PTR_W-1:0] dp_avail;
    logic [DST_X_W-1:0]      dp_dst_x;
    logic [DST_Y_W-1:0]      dp_dst_y;
    logic [DST_FBITS_W-1:0]  dp_dst_fbits;
    logic                    dp_enough;

    tcp_msg_poller_dispatch_datap #(
        .POLLER_PTR_W (POLLER_PTR_W)
    ) u_datap (
        .clk            (clk),
        .capture_flowid (capture_flowid),
        .flowid_in      (msg_req_q_rd_data),
        .capture_meta   (capture_meta),
        .meta_in        (msg_req_mem_rd_resp_data),
        .head_in        (ptr_mem_rd_resp_head),
        .commit_in      (ptr_mem_rd_resp_commit),
        .flowid         (dp_flowid),
        .avail          (dp_avail),
        .dst_x          (dp_dst_x),
        .dst_y          (dp_dst_y),
        .dst_fbits      (dp_dst_fbits),
        .enough         (dp_enough)
    );

    // State register; reset drops any in-flight flow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and outputs; every output is zero unless its state drives it
    always_comb begin
        state_next                 = state;
        capture_flowid             = 1'b0;
        capture_meta               = 1'b0;
        msg_req_q_rd_req           = 1'b0;
        msg_req_q_wr_req_val       = 1'b0;
        msg_req_q_wr_req_data      = '0;
        msg_req_mem_rd_req_addr    = '0;
        ptr_mem_rd_req_addr        = '0;
        active_bitvec_clear_val    = 1'b0;
        active_bitvec_clear_flowid = '0;
        poller_dst_msg_val         = 1'b0;
        poller_dst_msg_flowid      = '0;
        poller_dst_msg_len         = '0;
        poller_dst_msg_dst_x       = '0;
        poller_dst_msg_dst_y       = '0;
        poller_dst_msg_dst_fbits   = '0;
        case (state)
            ST_IDLE: begin
                if (!msg_req_q_empty) begin
                    msg_req_q_rd_req        = 1'b1;
                    capture_flowid          = 1'b1;
                    msg_req_mem_rd_req_addr = msg_req_q_rd_data;
                    ptr_mem_rd_req_addr     = msg_req_q_rd_data;
                    state_next              = ST_RD_META;
                end
            end
            ST_RD_META: begin
                capture_meta = 1'b1;
                state_next   = ST_CHECK;
            end
            ST_CHECK: begin
                state_next = dp_enough ? ST_NOTIFY : ST_REQUEUE;
            end
            ST_NOTIFY: begin
                poller_dst_msg_val       = 1'b1;
                poller_dst_msg_flowid    = dp_flowid;
                poller_dst_msg_len       = dp_avail;
                poller_dst_msg_dst_x     = dp_dst_x;
                poller_dst_msg_dst_y     = dp_dst_y;
                poller_dst_msg_dst_fbits = dp_dst_fbits;
                if (poller_dst_msg_rdy) begin
                    active_bitvec_clear_val    = 1'b1;
                    active_bitvec_clear_flowid = dp_flowid;
                    state_next                 = ST_IDLE;
                end
            end
            ST_REQUEUE: begin
                msg_req_q_wr_req_val  = 1'b1;
                msg_req_q_wr_req_data = dp_flowid;
                if (msg_req_q_wr_req_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef TCP_MSG_POLLER_DISPATCH_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Handshake counters, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_notify_cnt  <= '0;
            stat_requeue_cnt <= '0;
        end else begin
            if (poller_dst_msg_val && poller_dst_msg_rdy) begin
                stat_notify_cnt <= sat_inc32(stat_notify_cnt);
            end
            if (msg_req_q_wr_req_val && msg_req_q_wr_req_rdy) begin
                stat_requeue_cnt <= sat_inc32(stat_requeue_cnt);
            end
        end
    end
`endif

endmodule
